// File: rtl/param_register_file_if.sv
// Bus-side signals of the register bank: write port, registered read port
// and the data-memory bypass onto BOUT.
interface param_register_file_if #(
  parameter int DATA_W = 16,
  parameter int SEL_W  = 3
);
  logic              WE;
  logic [SEL_W-1:0]  WSEL;
  logic [DATA_W-1:0] BIN;
  logic              RE;
  logic [SEL_W-1:0]  RSEL;
  logic              MEMREAD;
  logic [DATA_W-1:0] DIN;
  logic [DATA_W-1:0] REGOUT;
  logic [DATA_W-1:0] BOUT;

  modport master (
    output WE, WSEL, BIN, RE, RSEL, MEMREAD, DIN,
    input  REGOUT, BOUT
  );

  modport slave (
    input  WE, WSEL, BIN, RE, RSEL, MEMREAD, DIN,
    output REGOUT, BOUT
  );
endinterface

// File: rtl/param_register_file.sv
// Parametrised register bank with bus and ALU read ports, per-register
// increment/clear and a clear-all sweep sequencer.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | normal operation, accepts SWEEP
// SWEEPING | clears reg[idx] each cycle, bus/INC/CLR updates blocked
// DONE     | one-cycle SWEEP_DONE pulse, then back to IDLE
module param_register_file #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int SEL_W    = 3
) (
  input  logic                  clk,
  input  logic                  RST,
  param_register_file_if.slave  bus,
  input  logic                  INC,
  input  logic [SEL_W-1:0]      INCSEL,
  input  logic                  CLR,
  input  logic [SEL_W-1:0]      CLRSEL,
  input  logic                  SWEEP,
  input  logic [SEL_W-1:0]      ASEL,
  output logic [DATA_W-1:0]     ALUOUT,
  output logic                  INC_OVF,
  output logic                  BUSY,
  output logic                  SWEEP_DONE
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SWEEPING = 2'd1,
    DONE     = 2'd2
  } state_t;

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_REGS - 1);

  state_t            state_q;
  logic [SEL_W-1:0]  idx_q;
  logic              busy_q;
  logic              sweep_done_q;

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [DATA_W-1:0] regout_q, regout_d;
  logic [DATA_W-1:0] aluout_q, aluout_d;
  logic              inc_ovf_q, inc_ovf_d;
  logic              sweeping;

  assign sweeping = (state_q == SWEEPING);

  // Per-register arbitration: sweep clear > CLR > WE > INC; out-of-range
  // selectors never match any index and so fall through as no-ops.
  always_comb begin
    regs_d    = regs_q;
    inc_ovf_d = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (sweeping) begin
        if (idx_q == SEL_W'(i)) regs_d[i] = '0;
      end else if (CLR && CLRSEL == SEL_W'(i)) begin
        regs_d[i] = '0;
      end else if (bus.WE && bus.WSEL == SEL_W'(i)) begin
        regs_d[i] = bus.BIN;
      end else if (INC && INCSEL == SEL_W'(i)) begin
        regs_d[i] = regs_q[i] + 1'b1;
        if (&regs_q[i]) inc_ovf_d = 1'b1;
      end
    end
  end

  always_comb begin
    regout_d = regout_q;
    if (bus.RE) begin
      regout_d = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (bus.RSEL == SEL_W'(i)) regout_d = regs_q[i];
      end
    end
    aluout_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ASEL == SEL_W'(i)) aluout_d = regs_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      regout_q  <= '0;
      aluout_q  <= '0;
      inc_ovf_q <= 1'b0;
    end else begin
      regs_q    <= regs_d;
      regout_q  <= regout_d;
      aluout_q  <= aluout_d;
      inc_ovf_q <= inc_ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      busy_q       <= 1'b0;
      sweep_done_q <= 1'b0;
    end else begin
      sweep_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (SWEEP) begin
            state_q <= SWEEPING;
            idx_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        SWEEPING: begin
          idx_q <= idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            state_q      <= DONE;
            busy_q       <= 1'b0;
            sweep_done_q <= 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.REGOUT = regout_q;
  assign bus.BOUT   = bus.MEMREAD ? bus.DIN : regout_q;
  assign ALUOUT     = aluout_q;
  assign INC_OVF    = inc_ovf_q;
  assign BUSY       = busy_q;
  assign SWEEP_DONE = sweep_done_q;

endmodule

// File: tb/tb_param_register_file.sv
// Directed bench for param_register_file: expected values go into a
// scoreboard queue when stimulus is applied and are popped against outputs.
module tb_param_register_file;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        RST;
  logic        INC, CLR, SWEEP;
  logic [2:0]  INCSEL, CLRSEL, ASEL;
  logic [15:0] ALUOUT;
  logic        INC_OVF, BUSY, SWEEP_DONE;

  logic        INC2, CLR2, SWEEP2;
  logic [4:0]  INCSEL2, CLRSEL2, ASEL2;
  logic [31:0] ALUOUT2;
  logic        INC_OVF2, BUSY2, SWEEP_DONE2;

  param_register_file_if #(.DATA_W(16), .SEL_W(3)) bus  ();
  param_register_file_if #(.DATA_W(32), .SEL_W(5)) bus2 ();

  param_register_file #(.DATA_W(16), .NUM_REGS(8), .SEL_W(3)) dut (
    .clk(clk), .RST(RST), .bus(bus),
    .INC(INC), .INCSEL(INCSEL), .CLR(CLR), .CLRSEL(CLRSEL),
    .SWEEP(SWEEP), .ASEL(ASEL), .ALUOUT(ALUOUT),
    .INC_OVF(INC_OVF), .BUSY(BUSY), .SWEEP_DONE(SWEEP_DONE)
  );

  param_register_file #(.DATA_W(32), .NUM_REGS(16), .SEL_W(5)) dut2 (
    .clk(clk), .RST(RST), .bus(bus2),
    .INC(INC2), .INCSEL(INCSEL2), .CLR(CLR2), .CLRSEL(CLRSEL2),
    .SWEEP(SWEEP2), .ASEL(ASEL2), .ALUOUT(ALUOUT2),
    .INC_OVF(INC_OVF2), .BUSY(BUSY2), .SWEEP_DONE(SWEEP_DONE2)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   busy_cnt, done_cnt;

  task automatic push_exp(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb_q.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    exp_t e;
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_err++;
      $error("FAIL sb_empty: observed %h with no expected value queued", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.exp) else begin
        n_err++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    push_exp(tag, exp);
    pop_check(obs);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write1(input logic [2:0] sel, input logic [15:0] d);
    bus.WE = 1'b1; bus.WSEL = sel; bus.BIN = d;
    tick();
    bus.WE = 1'b0;
  endtask

  task automatic read1(input logic [2:0] sel, input logic [15:0] exp, input string tag);
    bus.RE = 1'b1; bus.RSEL = sel;
    push_exp(tag, 32'(exp));
    tick();
    bus.RE = 1'b0;
    pop_check(32'(bus.REGOUT));
  endtask

  task automatic write2(input logic [4:0] sel, input logic [31:0] d);
    bus2.WE = 1'b1; bus2.WSEL = sel; bus2.BIN = d;
    tick();
    bus2.WE = 1'b0;
  endtask

  task automatic read2(input logic [4:0] sel, input logic [31:0] exp, input string tag);
    bus2.RE = 1'b1; bus2.RSEL = sel;
    push_exp(tag, exp);
    tick();
    bus2.RE = 1'b0;
    pop_check(bus2.REGOUT);
  endtask

  initial begin
    RST = 1'b1;
    INC = 1'b0; CLR = 1'b0; SWEEP = 1'b0; INCSEL = '0; CLRSEL = '0; ASEL = '0;
    bus.WE = 1'b0; bus.WSEL = '0; bus.BIN = '0; bus.RE = 1'b0; bus.RSEL = '0;
    bus.MEMREAD = 1'b0; bus.DIN = '0;
    INC2 = 1'b0; CLR2 = 1'b0; SWEEP2 = 1'b0; INCSEL2 = '0; CLRSEL2 = '0; ASEL2 = '0;
    bus2.WE = 1'b0; bus2.WSEL = '0; bus2.BIN = '0; bus2.RE = 1'b0; bus2.RSEL = '0;
    bus2.MEMREAD = 1'b0; bus2.DIN = '0;

    // reset state
    tick(); tick();
    RST = 1'b0;
    chk("rst_regout",  32'(bus.REGOUT), 32'h0);
    chk("rst_aluout",  32'(ALUOUT),     32'h0);
    chk("rst_inc_ovf", 32'(INC_OVF),    32'h0);
    chk("rst_busy",    32'(BUSY),       32'h0);
    chk("rst_done",    32'(SWEEP_DONE), 32'h0);

    // write / read / BOUT mux
    write1(3'd3, 16'hA5A5);
    read1(3'd3, 16'hA5A5, "rd_reg3");
    bus.MEMREAD = 1'b0; #1;
    chk("bout_reg", 32'(bus.BOUT), 32'h0000_A5A5);
    bus.DIN = 16'h1234; bus.MEMREAD = 1'b1; #1;
    chk("bout_mem", 32'(bus.BOUT), 32'h0000_1234);
    bus.MEMREAD = 1'b0;
    tick();
    chk("regout_hold", 32'(bus.REGOUT), 32'h0000_A5A5);

    // arbitration: WE beats INC on reg2, CLR on reg5 in the same cycle
    write1(3'd5, 16'h0077);
    write1(3'd6, 16'h0055);
    bus.WE = 1'b1; bus.WSEL = 3'd2; bus.BIN = 16'h0010;
    INC = 1'b1; INCSEL = 3'd2;
    CLR = 1'b1; CLRSEL = 3'd5;
    tick();
    bus.WE = 1'b0; INC = 1'b0; CLR = 1'b0;
    read1(3'd2, 16'h0010, "we_beats_inc");
    read1(3'd5, 16'h0000, "clr_reg5");
    bus.WE = 1'b1; bus.WSEL = 3'd6; bus.BIN = 16'h1111;
    CLR = 1'b1; CLRSEL = 3'd6;
    tick();
    bus.WE = 1'b0; CLR = 1'b0;
    read1(3'd6, 16'h0000, "clr_beats_we");
    INC = 1'b1; INCSEL = 3'd2;
    tick();
    INC = 1'b0;
    read1(3'd2, 16'h0011, "inc_reg2");

    // increment wrap and overflow pulse
    write1(3'd1, 16'hFFFF);
    INC = 1'b1; INCSEL = 3'd1;
    tick();
    INC = 1'b0;
    chk("ovf_pulse", 32'(INC_OVF), 32'h1);
    tick();
    chk("ovf_one_cycle", 32'(INC_OVF), 32'h0);
    read1(3'd1, 16'h0000, "inc_wrap");
    write1(3'd1, 16'hFFFE);
    INC = 1'b1; INCSEL = 3'd1;
    tick();
    INC = 1'b0;
    chk("no_ovf_fffe", 32'(INC_OVF), 32'h0);
    read1(3'd1, 16'hFFFF, "inc_fffe");
    bus.WE = 1'b1; bus.WSEL = 3'd1; bus.BIN = 16'h0042;
    INC = 1'b1; INCSEL = 3'd1;
    tick();
    bus.WE = 1'b0; INC = 1'b0;
    chk("no_ovf_lost_arb", 32'(INC_OVF), 32'h0);
    read1(3'd1, 16'h0042, "we_beats_inc_ffff");

    // full sweep, WE dropped while busy, SWEEP ignored while busy and in DONE
    for (int i = 0; i < 8; i++) write1(3'(i), 16'(16'h0100 + i));
    SWEEP = 1'b1;
    tick();
    SWEEP = 1'b0;
    busy_cnt = 0;
    done_cnt = 0;
    for (int j = 0; j < 14; j++) begin
      if (BUSY) busy_cnt++;
      if (SWEEP_DONE) done_cnt++;
      if (j == 2) begin
        bus.WE = 1'b1; bus.WSEL = 3'd0; bus.BIN = 16'hBEEF;
      end else begin
        bus.WE = 1'b0;
      end
      SWEEP = (j == 4) || SWEEP_DONE;
      tick();
    end
    bus.WE = 1'b0; SWEEP = 1'b0;
    chk("sweep_busy_cycles", 32'(busy_cnt), 32'd8);
    chk("sweep_done_pulses", 32'(done_cnt), 32'd1);
    chk("sweep_idle_busy",   32'(BUSY),     32'h0);
    for (int i = 0; i < 8; i++) read1(3'(i), 16'h0000, $sformatf("swept_reg%0d", i));

    // reset in the 4th sweep cycle
    write1(3'd5, 16'h0505);
    write1(3'd6, 16'h0606);
    write1(3'd7, 16'h0707);
    SWEEP = 1'b1;
    tick();
    SWEEP = 1'b0;
    tick(); tick(); tick();
    chk("busy_before_rst", 32'(BUSY), 32'h1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("rst_mid_busy", 32'(BUSY),       32'h0);
    chk("rst_mid_done", 32'(SWEEP_DONE), 32'h0);
    done_cnt = 0;
    for (int j = 0; j < 12; j++) begin
      if (SWEEP_DONE) done_cnt++;
      tick();
    end
    chk("rst_mid_no_done", 32'(done_cnt), 32'd0);
    read1(3'd5, 16'h0000, "rst_mid_reg5");
    read1(3'd6, 16'h0000, "rst_mid_reg6");
    read1(3'd7, 16'h0000, "rst_mid_reg7");

    // ALU port has no write bypass
    write1(3'd4, 16'h0011);
    ASEL = 3'd4;
    tick();
    chk("alu_pre", 32'(ALUOUT), 32'h0000_0011);
    bus.WE = 1'b1; bus.WSEL = 3'd4; bus.BIN = 16'h00C3;
    tick();
    bus.WE = 1'b0;
    chk("alu_old", 32'(ALUOUT), 32'h0000_0011);
    tick();
    chk("alu_new", 32'(ALUOUT), 32'h0000_00C3);

    // wide instance: index 15 and out-of-range selectors
    write2(5'd15, 32'h1111_2222);
    ASEL2 = 5'd15;
    tick();
    chk("alu2_pre", ALUOUT2, 32'h1111_2222);
    bus2.WE = 1'b1; bus2.WSEL = 5'd15; bus2.BIN = 32'hCAFE_00C3;
    tick();
    bus2.WE = 1'b0;
    chk("alu2_old", ALUOUT2, 32'h1111_2222);
    tick();
    chk("alu2_new", ALUOUT2, 32'hCAFE_00C3);
    write2(5'd20, 32'hFFFF_FFFF);
    read2(5'd20, 32'h0, "oor_read");
    read2(5'd15, 32'hCAFE_00C3, "rd2_reg15");
    ASEL2 = 5'd20;
    tick();
    chk("oor_alu", ALUOUT2, 32'h0);

    if (sb_q.size() != 0) begin
      n_err++;
      $error("FAIL sb_leftover: observed %0d entries expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
